// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered 4-digit common-anode 7-segment scan driver with blanking
// Optional feature macro: BRIGHTNESS_PWM_EN (adds brightness[3:0] PWM dimming of digit enables)
module seg7_scan_driver #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [19:0] frame_data,
  output logic        frame_start,
  output logic [3:0]  digit_sel,
  output logic [7:0]  segments
`ifdef BRIGHTNESS_PWM_EN
  ,
  input  logic [3:0]  brightness
`endif
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_TICKS - 1);

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} phase_t;

  phase_t        phase, phase_nxt;
  logic [1:0]    digit, digit_nxt;
  logic [CW-1:0] tick, tick_nxt;
  logic [3:0]    sel_nxt;
  logic [7:0]    seg_nxt;
  logic          start_nxt;
  logic          boundary;
  logic [4:0]    field;
  logic [19:0]   shadow, active;
  logic          shadow_full;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]    pwm, pwm_nxt;
`endif

  // Symbol {dp, sym} to active-low {dp,g,f,e,d,c,b,a}.
  function automatic logic [7:0] decode(input logic [4:0] f);
    logic [7:0] s;
    case (f[3:0])
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'hC7;
      4'hB: s = 8'h89;
      4'hC: s = 8'hA3;
      4'hD: s = 8'hFB;
      4'hE: s = 8'hBF;
      default: s = 8'hFF;
    endcase
    if (f[4]) s[7] = 1'b0;
    return s;
  endfunction

  assign frame_ready = ~shadow_full;

  // Next phase/digit/tick and the output values that load with them.
  always_comb begin
    phase_nxt = phase;
    digit_nxt = digit;
    tick_nxt  = tick + CW'(1);
    start_nxt = 1'b0;
    boundary  = 1'b0;
    case (phase)
      BLANK: begin
        if (tick == BLANK_LAST) begin
          phase_nxt = DRIVE;
          tick_nxt  = '0;
        end
      end
      DRIVE: begin
        if (tick == DRIVE_LAST) begin
          phase_nxt = BLANK;
          tick_nxt  = '0;
          digit_nxt = digit + 2'd1;
          if (digit == 2'd3) begin
            boundary  = 1'b1;
            start_nxt = 1'b1;
          end
        end
      end
      default: begin
        phase_nxt = BLANK;
        tick_nxt  = '0;
      end
    endcase

    case (digit_nxt)
      2'd0:    field = active[4:0];
      2'd1:    field = active[9:5];
      2'd2:    field = active[14:10];
      default: field = active[19:15];
    endcase

    sel_nxt = 4'hF;
    seg_nxt = 8'hFF;
    if (phase_nxt == DRIVE) begin
      sel_nxt = ~(4'b0001 << digit_nxt);
      seg_nxt = decode(field);
    end

`ifdef BRIGHTNESS_PWM_EN
    pwm_nxt = (phase == DRIVE && phase_nxt == DRIVE) ? pwm + 4'd1 : 4'd0;
    if (phase_nxt == DRIVE && pwm_nxt > brightness) sel_nxt = 4'hF;
`endif
  end

  // Scan state and registered display outputs; all fields load on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= BLANK;
      digit       <= 2'd0;
      tick        <= '0;
      digit_sel   <= 4'hF;
      segments    <= 8'hFF;
      frame_start <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
      pwm         <= 4'd0;
`endif
    end else begin
      phase       <= phase_nxt;
      digit       <= digit_nxt;
      tick        <= tick_nxt;
      digit_sel   <= sel_nxt;
      segments    <= seg_nxt;
      frame_start <= start_nxt;
`ifdef BRIGHTNESS_PWM_EN
      pwm         <= pwm_nxt;
`endif
    end
  end

  // Shadow capture on handshake; promotion to the active frame only at the frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow      <= '0;
      shadow_full <= 1'b0;
      active      <= {4{5'h0F}};
    end else if (frame_valid && frame_ready) begin
      shadow      <= frame_data;
      shadow_full <= 1'b1;
    end else if (boundary && shadow_full) begin
      active      <= shadow;
      shadow_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [19:0] frame_data = '0;
  logic        frame_ready;
  logic        frame_start;
  logic [3:0]  digit_sel;
  logic [7:0]  segments;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  seg7_scan_driver #(.DIGIT_TICKS(8), .BLANK_TICKS(2)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .frame_start(frame_start), .digit_sel(digit_sel),
    .segments(segments)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; one frame scan is 40 cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic goto(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % 40) != p && n < 60);
    if ((cyc % 40) != p) begin
      n_cmp++; n_bad++;
      $display("FAIL goto position actual=%0d expected=%0d", cyc % 40, p);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (digit_sel !== 4'hF) begin n_bad++; $display("FAIL reset_sel actual=%h expected=f", digit_sel); end
    n_cmp++; if (segments !== 8'hFF) begin n_bad++; $display("FAIL reset_seg actual=%h expected=ff", segments); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_start actual=%b expected=0", frame_start); end
    reset = 1'b0;
    #1;
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready actual=%b expected=1", frame_ready); end
  endtask

  task automatic test_idle_scan;
    for (int i = 0; i < 80; i++) begin
      int p, d;
      logic [3:0] es;
      logic est;
      p = i % 40;
      d = p / 10;
      es = ((p % 10) < 2) ? 4'hF : ~(4'b0001 << d);
      est = (p == 0 && i >= 40);
      n_cmp++; if (digit_sel !== es) begin n_bad++; $display("FAIL idle_sel cyc=%0d actual=%h expected=%h", i, digit_sel, es); end
      n_cmp++; if (segments !== 8'hFF) begin n_bad++; $display("FAIL idle_seg cyc=%0d actual=%h expected=ff", i, segments); end
      n_cmp++; if (frame_start !== est) begin n_bad++; $display("FAIL idle_start cyc=%0d actual=%b expected=%b", i, frame_start, est); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] exp_seg [4] = '{8'hF9, 8'hA4, 8'hB0, 8'hC0};
    goto(3);
    frame_valid = 1'b1;
    frame_data = {5'h00, 5'h03, 5'h02, 5'h01};
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_before actual=%b expected=1", frame_ready); end
    @(negedge clk);
    frame_valid = 1'b0;
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_after actual=%b expected=0", frame_ready); end
    goto(35);
    n_cmp++; if (segments !== 8'hFF) begin n_bad++; $display("FAIL single_no_tear actual=%h expected=ff", segments); end
    goto(39);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_boundary actual=%b expected=0", frame_ready); end
    goto(0);
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_promoted actual=%b expected=1", frame_ready); end
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL single_start actual=%b expected=1", frame_start); end
    for (int d = 0; d < 4; d++) begin
      logic [3:0] es;
      es = ~(4'b0001 << d);
      goto(d * 10 + 5);
      n_cmp++; if (digit_sel !== es) begin n_bad++; $display("FAIL single_sel d=%0d actual=%h expected=%h", d, digit_sel, es); end
      n_cmp++; if (segments !== exp_seg[d]) begin n_bad++; $display("FAIL single_seg d=%0d actual=%h expected=%h", d, segments, exp_seg[d]); end
    end
    goto(1);
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL single_start_width actual=%b expected=0", frame_start); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seg_a [4] = '{8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] seg_b [4] = '{8'h80, 8'h90, 8'hC0, 8'hBF};
    goto(3);
    frame_valid = 1'b1;
    frame_data = {5'h07, 5'h06, 5'h05, 5'h04};
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_a actual=%b expected=1", frame_ready); end
    @(negedge clk);
    frame_data = {5'h0E, 5'h00, 5'h09, 5'h08};
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_wait actual=%b expected=0", frame_ready); end
    goto(39);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_boundary actual=%b expected=0", frame_ready); end
    goto(0);
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_b actual=%b expected=1", frame_ready); end
    @(negedge clk);
    frame_valid = 1'b0;
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_b_taken actual=%b expected=0", frame_ready); end
    for (int d = 0; d < 4; d++) begin
      goto(d * 10 + 5);
      n_cmp++; if (segments !== seg_a[d]) begin n_bad++; $display("FAIL b2b_seg_a d=%0d actual=%h expected=%h", d, segments, seg_a[d]); end
    end
    for (int d = 0; d < 4; d++) begin
      goto(d * 10 + 5);
      n_cmp++; if (segments !== seg_b[d]) begin n_bad++; $display("FAIL b2b_seg_b d=%0d actual=%h expected=%h", d, segments, seg_b[d]); end
    end
  endtask

  task automatic test_boundary_handshake;
    logic [7:0] seg_b [4] = '{8'h80, 8'h90, 8'hC0, 8'hBF};
    logic [7:0] seg_c [4] = '{8'hA4, 8'hF9, 8'hC0, 8'h90};
    goto(39);
    frame_valid = 1'b1;
    frame_data = {5'h09, 5'h00, 5'h01, 5'h02};
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL bnd_ready actual=%b expected=1", frame_ready); end
    @(negedge clk);
    frame_valid = 1'b0;
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL bnd_ready_taken actual=%b expected=0", frame_ready); end
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL bnd_start actual=%b expected=1", frame_start); end
    for (int d = 0; d < 4; d++) begin
      goto(d * 10 + 5);
      n_cmp++; if (segments !== seg_b[d]) begin n_bad++; $display("FAIL bnd_seg_old d=%0d actual=%h expected=%h", d, segments, seg_b[d]); end
    end
    for (int d = 0; d < 4; d++) begin
      goto(d * 10 + 5);
      n_cmp++; if (segments !== seg_c[d]) begin n_bad++; $display("FAIL bnd_seg_new d=%0d actual=%h expected=%h", d, segments, seg_c[d]); end
    end
  endtask

  task automatic test_decode_dp;
    logic [7:0] seg_d [4] = '{8'h89, 8'hA3, 8'h47, 8'hFB};
    goto(37);
    frame_valid = 1'b1;
    frame_data = {5'h0D, 5'h1A, 5'h0C, 5'h0B};
    @(negedge clk);
    frame_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      goto(d * 10 + 5);
      n_cmp++; if (segments !== seg_d[d]) begin n_bad++; $display("FAIL decode_seg d=%0d actual=%h expected=%h", d, segments, seg_d[d]); end
    end
  endtask

  task automatic test_reset_mid_scan;
    goto(2);
    frame_valid = 1'b1;
    frame_data = {5'h08, 5'h08, 5'h08, 5'h08};
    @(negedge clk);
    frame_valid = 1'b0;
    goto(25);
    n_cmp++; if (digit_sel !== 4'b1011) begin n_bad++; $display("FAIL midrst_pre_sel actual=%h expected=b", digit_sel); end
    n_cmp++; if (segments !== 8'h47) begin n_bad++; $display("FAIL midrst_pre_seg actual=%h expected=47", segments); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_ready actual=%b expected=0", frame_ready); end
    reset = 1'b1;
    #1;
    n_cmp++; if (digit_sel !== 4'hF) begin n_bad++; $display("FAIL midrst_sel actual=%h expected=f", digit_sel); end
    n_cmp++; if (segments !== 8'hFF) begin n_bad++; $display("FAIL midrst_seg actual=%h expected=ff", segments); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready actual=%b expected=1", frame_ready); end
    n_cmp++; if (digit_sel !== 4'hF) begin n_bad++; $display("FAIL midrst_blank_phase actual=%h expected=f", digit_sel); end
    goto(2);
    n_cmp++; if (digit_sel !== 4'b1110) begin n_bad++; $display("FAIL midrst_digit0 actual=%h expected=e", digit_sel); end
    n_cmp++; if (segments !== 8'hFF) begin n_bad++; $display("FAIL midrst_seg_blank actual=%h expected=ff", segments); end
    goto(0);
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL midrst_start actual=%b expected=1", frame_start); end
    goto(5);
    n_cmp++; if (segments !== 8'hFF) begin n_bad++; $display("FAIL midrst_shadow_dropped actual=%h expected=ff", segments); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_frame();
    test_back_to_back();
    test_boundary_handshake();
    test_decode_dp();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
